// File: rtl/se_sequencer_if.sv
// Control, table-write and tone-output bundle between the game logic and the note sequencer.
// Master drives trigger/stop/table writes; slave returns the registered tone outputs.
interface se_sequencer_if #(
  parameter int ADDR_W = 4,
  parameter int FREQ_W = 16,
  parameter int DUR_W  = 32
) ();
  logic              iTrig;
  logic              iStop;
  logic              iLoop;
  logic [ADDR_W:0]   iLength;
  logic              iWrEn;
  logic [ADDR_W-1:0] iWrAddr;
  logic [FREQ_W-1:0] iWrFreq;
  logic [DUR_W-1:0]  iWrDur;
  logic              oEnable;
  logic [FREQ_W-1:0] oFreq;
  logic [ADDR_W-1:0] oNoteIndex;
  logic              oDone;

  modport master (
    output iTrig, iStop, iLoop, iLength, iWrEn, iWrAddr, iWrFreq, iWrDur,
    input  oEnable, oFreq, oNoteIndex, oDone
  );

  modport slave (
    input  iTrig, iStop, iLoop, iLength, iWrEn, iWrAddr, iWrFreq, iWrDur,
    output oEnable, oFreq, oNoteIndex, oDone
  );
endinterface

// File: rtl/se_sequencer.sv
// Programmable (freq, dur) note sequencer: one-shot or loop, stop/retrigger; outputs change one cycle after the deciding edge.
// No backpressure: the tone generator consumes oEnable/oFreq every cycle, iTrig is a level sampled per cycle.
module se_sequencer #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int FREQ_W = 16,
  parameter int DUR_W  = 32
) (
  input  logic           iClock,
  input  logic           iReset,
  se_sequencer_if.slave  bus
);

  typedef enum logic {IDLE, PLAY} state_t;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [FREQ_W-1:0] r_tab_freq [DEPTH];
  logic [DUR_W-1:0]  r_tab_dur  [DEPTH];

  state_t            r_state;
  logic [ADDR_W:0]   r_len;
  logic              r_loop;
  logic [ADDR_W-1:0] r_idx;
  logic [FREQ_W-1:0] r_freq;
  logic [DUR_W-1:0]  r_dur;
  logic [DUR_W-1:0]  r_timer;
  logic              r_done;

  state_t            w_state_nxt;
  logic              w_accept;
  logic              w_note_end;
  logic [ADDR_W:0]   w_idx_inc;
  logic              w_load;
  logic [ADDR_W-1:0] w_load_idx;
  logic              w_clear;
  logic              w_done_nxt;
  logic [ADDR_W:0]   w_len_nxt;
  logic              w_loop_nxt;

  // Table has no reset so the game logic can keep effects programmed across resets.
  always_ff @(posedge iClock) begin
    if (bus.iWrEn && ({1'b0, bus.iWrAddr} < DEPTH_L)) begin
      r_tab_freq[bus.iWrAddr] <= bus.iWrFreq;
      r_tab_dur[bus.iWrAddr]  <= bus.iWrDur;
    end
  end

  assign w_accept   = bus.iTrig && (bus.iLength != '0) && (bus.iLength <= DEPTH_L);
  assign w_note_end = (r_dur == '0) || (r_timer == r_dur - 1'b1);
  assign w_idx_inc  = {1'b0, r_idx} + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_idx  = '0;
    w_clear     = 1'b0;
    w_done_nxt  = 1'b0;
    w_len_nxt   = r_len;
    w_loop_nxt  = r_loop;
    if (bus.iStop) begin
      w_state_nxt = IDLE;
      w_clear     = 1'b1;
    end else if (w_accept) begin
      w_state_nxt = PLAY;
      w_load      = 1'b1;
      w_len_nxt   = bus.iLength;
      w_loop_nxt  = bus.iLoop;
    end else if (r_state == PLAY && w_note_end) begin
      if (w_idx_inc < r_len) begin
        w_load     = 1'b1;
        w_load_idx = w_idx_inc[ADDR_W-1:0];
      end else if (r_loop) begin
        w_load = 1'b1;
      end else begin
        w_state_nxt = IDLE;
        w_clear     = 1'b1;
        w_done_nxt  = 1'b1;
      end
    end
  end

  // Note freq/dur are copied out of the table at note start, so later writes never disturb a sounding note.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_state <= IDLE;
      r_len   <= '0;
      r_loop  <= 1'b0;
      r_idx   <= '0;
      r_freq  <= '0;
      r_dur   <= '0;
      r_timer <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_len   <= w_len_nxt;
      r_loop  <= w_loop_nxt;
      r_done  <= w_done_nxt;
      if (w_clear) begin
        r_idx   <= '0;
        r_freq  <= '0;
        r_dur   <= '0;
        r_timer <= '0;
      end else if (w_load) begin
        r_idx   <= w_load_idx;
        r_freq  <= r_tab_freq[w_load_idx];
        r_dur   <= r_tab_dur[w_load_idx];
        r_timer <= '0;
      end else if (r_state == PLAY) begin
        r_timer <= r_timer + 1'b1;
      end
    end
  end

  assign bus.oEnable    = (r_state == PLAY);
  assign bus.oFreq      = r_freq;
  assign bus.oNoteIndex = r_idx;
  assign bus.oDone      = r_done;

endmodule

// File: doc/se_sequencer.md
Name: se_sequencer

Overview:
- Parametrised sound-effect note sequencer; successor to the single-note effect players.
- Plays a programmable table of (frequency, duration) notes on a trigger, with one-shot or loop mode, stop and retrigger.
- Drives the tone generator through oEnable/oFreq.
- Note table is written at run time by the game/CPU logic, so one block serves many effects.

Parameters:
DEPTH, 16, number of note-table entries
ADDR_W, 4, table index width; DEPTH <= 2**ADDR_W
FREQ_W, 16, note frequency width (0 = rest)
DUR_W, 32, note duration width in iClock cycles

Ports:
iClock  in  1  system clock
iReset  in  1  synchronous active-high reset
iTrig  in  1  start/restart sequence (level sampled each cycle)
iStop  in  1  abort playback
iLoop  in  1  loop mode, sampled on accepted trigger
iLength  in  ADDR_W+1  notes to play (1..DEPTH), sampled on accepted trigger
iWrEn  in  1  table write strobe
iWrAddr  in  ADDR_W  table write index
iWrFreq  in  FREQ_W  frequency to write
iWrDur  in  DUR_W  duration to write
oEnable  out  1  high while a sequence is playing (including rests)
oFreq  out  FREQ_W  current note frequency; 0 when idle or resting
oNoteIndex  out  ADDR_W  index of the note being played; 0 when idle
oDone  out  1  one-cycle pulse on natural end of a one-shot sequence

Behaviour:
- Reset: oEnable=0, oFreq=0, oNoteIndex=0, oDone=0, state IDLE. Reset does not clear the table; table contents after power-up are undefined.
- Table: DEPTH x (FREQ_W+DUR_W) registers, written synchronously when iWrEn=1. Writes with iWrAddr >= DEPTH are ignored. Writes are allowed during playback.
- Note latching: freq and dur are latched from the table in the cycle a note starts. A write to an entry takes effect the next time that entry starts, never mid-note.
- States: IDLE, PLAY.
- Priority per cycle: iReset > iStop > iTrig > note advance.
- Accepted trigger: iTrig=1 and 1 <= iLength <= DEPTH, in either state.
  - iLength=0 or iLength>DEPTH: the trigger is ignored and current state is kept.
- On an accepted trigger at edge T:
  - Latch len and loop.
  - Load entry 0 and clear the timer.
  - From T+1: oEnable=1, oNoteIndex=0, oFreq=entry0.freq.
  - A retrigger during PLAY restarts at note 0 the same way, with no idle gap.
  - Holding iTrig high restarts every cycle; callers pulse it.
- Note duration: each note occupies exactly max(dur,1) cycles. A timer counts 0..dur-1; when timer==dur-1 (or dur==0), the next note starts on the following edge.
- Rest: freq 0 gives oFreq=0 with oEnable still 1.
- Advance from index i:
  - i+1 < len: start note i+1.
  - i+1 == len and loop=1: start note 0.
  - i+1 == len and loop=0: go to IDLE. oEnable=0, oFreq=0, oNoteIndex=0 from the next cycle; oDone=1 for exactly that one cycle.
- iStop=1: go to IDLE next cycle with outputs cleared and no oDone. iStop in IDLE has no effect. iStop with iTrig in the same cycle: stop wins.
- Outputs are fully registered, with no combinational path from inputs to outputs.
- Timer width is DUR_W. The timer never wraps because it is compared against the latched dur.
- Reset mid-playback: IDLE next cycle, outputs cleared, no oDone.

Test Plan:
1. Write entry0=(150,5), entry1=(0,3), entry2=(300,4); len=3, loop=0; pulse iTrig at T.
   - oFreq=150 on T+1..T+5, 0 with oEnable=1 on T+6..T+8, 300 on T+9..T+12.
   - oEnable=0 and oDone=1 at T+13 only.
2. Same table, loop=1.
   - After entry2, oFreq returns to 150 at T+13 with no gap.
   - iStop at T+15 gives oEnable=0 at T+16 and oDone never asserts.
3. Retrigger at T+7 during scenario 1.
   - oFreq=150, oNoteIndex=0 at T+8; sequence completes at T+20.
4. Trigger with iLength=0 and with iLength=17 (DEPTH=16): no change, oEnable stays 0.
   - Same cycle iTrig+iStop while playing: stops.
5. During note 0 of scenario 1, write entry1=(200,2) at T+2.
   - Note 1 plays 200 for 2 cycles.
   - Write entry0 at T+3: current note unaffected.
6. Entry with dur=0: lasts exactly 1 cycle.
   - Assert iReset mid-note: all outputs 0 next cycle; table contents preserved (replay matches).
